// File: rtl/bus_arb_pkg.sv
// Shared types and defaults for the round-robin bus arbiter.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BUSY  = 2'd2,
    TURN  = 2'd3
  } arb_state_e;

  localparam int DEF_TIMEOUT_CYCLES = 1024;

  // Index reached by stepping 'step' places past 'id' in a ring of 'n' masters.
  function automatic int rr_next(input int id, input int step, input int n);
    return (id + step) % n;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin picker: searches from last_id+1 upward, wrapping,
// and reports the first requesting master.
module rr_picker
  import bus_arb_pkg::*;
#(
  parameter  int N_MASTERS = 3,
  localparam int IDW       = $clog2(N_MASTERS)
) (
  input  logic [N_MASTERS-1:0] req,
  input  logic [IDW-1:0]       last_id,
  output logic                 valid,
  output logic [IDW-1:0]       winner
);

  logic [IDW-1:0] cand;

  always_comb begin
    valid  = 1'b0;
    winner = '0;
    cand   = '0;
    // Step N_MASTERS places so last_id itself is the lowest priority.
    for (int i = 1; i <= N_MASTERS; i++) begin
      cand = IDW'(rr_next(int'(last_id), i, N_MASTERS));
      if (!valid && req[cand]) begin
        valid  = 1'b1;
        winner = cand;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with IDLE/GRANT/BUSY/TURN tenure FSM and registered outputs.
// Optional forced release of long tenures when ARB_TIMEOUT_EN is defined.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter  int N_MASTERS      = 3,
  parameter  int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  localparam int IDW            = $clog2(N_MASTERS)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [N_MASTERS-1:0] req,
  input  logic                 done,
  output logic [N_MASTERS-1:0] grant,
  output logic [IDW-1:0]       grant_id,
  output logic                 bus_busy,
  output logic                 timeout
);

  arb_state_e           state_q, state_d;
  logic [N_MASTERS-1:0] grant_q, grant_d;
  logic [IDW-1:0]       grant_id_q, grant_id_d;
  logic [IDW-1:0]       last_id_q, last_id_d;
  logic                 busy_q, busy_d;

  logic                 pick_vld;
  logic [IDW-1:0]       pick_id;
  logic                 release_c;
  logic                 tmo_hit;

  rr_picker #(.N_MASTERS(N_MASTERS)) u_picker (
    .req     (req),
    .last_id (last_id_q),
    .valid   (pick_vld),
    .winner  (pick_id)
  );

  // The holder is the only set bit of grant_q, so this sees only its own req.
  assign release_c = done | ~|(grant_q & req);

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;

  assign tmo_hit = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d     = '0;
    timeout_d = 1'b0;
    if (state_q == BUSY && !release_c) begin
      if (tmo_hit) timeout_d = 1'b1;
      else         cnt_d     = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  logic [31:0] unused_timeout_cycles;
  assign unused_timeout_cycles = TIMEOUT_CYCLES;
  assign tmo_hit = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    last_id_d  = last_id_q;
    busy_d     = busy_q;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        busy_d  = 1'b0;
        if (pick_vld) begin
          state_d    = GRANT;
          grant_d    = N_MASTERS'(1) << pick_id;
          grant_id_d = pick_id;
          busy_d     = 1'b1;
        end
      end
      GRANT: begin
        last_id_d = grant_id_q;
        state_d   = BUSY;
      end
      BUSY: begin
        // A normal release wins over the terminal count.
        if (release_c || tmo_hit) begin
          state_d = TURN;
          grant_d = '0;
          busy_d  = 1'b0;
        end
      end
      TURN: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      last_id_q  <= IDW'(N_MASTERS - 1);
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      last_id_q  <= last_id_d;
      busy_q     <= busy_d;
    end
  end

  assign grant    = grant_q;
  assign grant_id = grant_id_q;
  assign bus_busy = busy_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed, table-driven bench for bus_arbiter (3 masters, 16-cycle timeout).
module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       rstn;
  logic [2:0] req;
  logic       done;
  logic [2:0] grant;
  logic [1:0] grant_id;
  logic       bus_busy;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0] req;
    logic       done;
    logic [2:0] g;
    logic [1:0] id;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  bus_arbiter #(.N_MASTERS(3), .TIMEOUT_CYCLES(16)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .req      (req),
    .done     (done),
    .grant    (grant),
    .grant_id (grant_id),
    .bus_busy (bus_busy),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic [2:0] g, input logic [1:0] id,
                         input logic busy, input logic tmo);
    chk({name, ".grant"},    32'(grant),    32'(g));
    chk({name, ".grant_id"}, 32'(grant_id), 32'(id));
    chk({name, ".bus_busy"}, 32'(bus_busy), 32'(busy));
    chk({name, ".timeout"},  32'(timeout),  32'(tmo));
  endtask

  task automatic add(input logic [2:0] r, input logic d, input logic [2:0] g,
                     input logic [1:0] id, input logic busy);
    vec_t v;
    v.req = r; v.done = d; v.g = g; v.id = id; v.busy = busy;
    vecs.push_back(v);
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic tmo_tenure(input string name, input logic rel_at_tc);
    int tmo_seen;
    tmo_seen = 0;
    req = 3'b001; done = 1'b0;
    step();
    chk_out({name, ".grant"}, 3'b001, 2'd0, 1'b1, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      step();
      if (timeout !== 1'b0 || grant !== 3'b001) tmo_seen++;
    end
    chk({name, ".held16"}, 32'(tmo_seen), 32'd0);
    done = rel_at_tc;
    step();
    chk_out({name, ".end"}, 3'b000, 2'd0, 1'b0, !rel_at_tc);
    done = 1'b0; req = 3'b000;
    step();
    chk_out({name, ".after"}, 3'b000, 2'd0, 1'b0, 1'b0);
  endtask
`endif

  initial begin
    int tmo_seen;

    rstn = 1'b0; req = 3'b000; done = 1'b0;
    #12;
    chk_out("reset", 3'b000, 2'd0, 1'b0, 1'b0);
    rstn = 1'b1;

    // Three tenures under full contention, then release corner cases.
    add(3'b111, 0, 3'b001, 2'd0, 1);
    add(3'b111, 0, 3'b001, 2'd0, 1);
    add(3'b111, 1, 3'b000, 2'd0, 0);
    add(3'b111, 0, 3'b000, 2'd0, 0);
    add(3'b111, 0, 3'b010, 2'd1, 1);
    add(3'b111, 0, 3'b010, 2'd1, 1);
    add(3'b111, 0, 3'b010, 2'd1, 1);
    add(3'b111, 1, 3'b000, 2'd1, 0);
    add(3'b111, 0, 3'b000, 2'd1, 0);
    add(3'b111, 0, 3'b100, 2'd2, 1);
    add(3'b111, 0, 3'b100, 2'd2, 1);
    add(3'b111, 1, 3'b000, 2'd2, 0);
    add(3'b111, 0, 3'b000, 2'd2, 0);
    add(3'b111, 0, 3'b001, 2'd0, 1);
    add(3'b111, 0, 3'b001, 2'd0, 1);
    add(3'b110, 1, 3'b000, 2'd0, 0);
    add(3'b110, 0, 3'b000, 2'd0, 0);
    add(3'b110, 0, 3'b010, 2'd1, 1);
    add(3'b110, 0, 3'b010, 2'd1, 1);
    add(3'b100, 0, 3'b000, 2'd1, 0);
    add(3'b100, 1, 3'b000, 2'd1, 0);
    add(3'b000, 1, 3'b000, 2'd1, 0);
    add(3'b000, 0, 3'b000, 2'd1, 0);
    add(3'b001, 0, 3'b001, 2'd0, 1);
    add(3'b011, 0, 3'b001, 2'd0, 1);
    add(3'b011, 1, 3'b000, 2'd0, 0);
    add(3'b011, 0, 3'b000, 2'd0, 0);
    add(3'b011, 0, 3'b010, 2'd1, 1);
    add(3'b011, 0, 3'b010, 2'd1, 1);
    add(3'b011, 1, 3'b000, 2'd1, 0);
    add(3'b011, 0, 3'b000, 2'd1, 0);
    add(3'b011, 0, 3'b001, 2'd0, 1);
    add(3'b011, 1, 3'b001, 2'd0, 1);
    add(3'b000, 0, 3'b000, 2'd0, 0);
    add(3'b000, 0, 3'b000, 2'd0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      req  = vecs[i].req;
      done = vecs[i].done;
      step();
      chk_out($sformatf("vec%0d", i), vecs[i].g, vecs[i].id, vecs[i].busy, 1'b0);
    end
    done = 1'b0;

    // Reset in the middle of a tenure held by master 2.
    req = 3'b100;
    step();
    step();
    chk_out("pre_rst", 3'b100, 2'd2, 1'b1, 1'b0);
    #2 rstn = 1'b0;
    #1 chk_out("async_rst", 3'b000, 2'd0, 1'b0, 1'b0);
    #2 rstn = 1'b1;
    req = 3'b101;
    step();
    chk_out("post_rst", 3'b001, 2'd0, 1'b1, 1'b0);
    req = 3'b000;
    step();
    step();
    step();
    chk_out("post_rst_idle", 3'b000, 2'd0, 1'b0, 1'b0);

    // Single tenure: grant for 7 cycles, released by done.
    req = 3'b010;
    step();
    chk_out("t32.first", 3'b010, 2'd1, 1'b1, 1'b0);
    for (int i = 7; i <= 12; i++) begin
      step();
      chk_out($sformatf("t32.c%0d", i), 3'b010, 2'd1, 1'b1, 1'b0);
    end
    done = 1'b1;
    step();
    chk_out("t32.c13", 3'b000, 2'd1, 1'b0, 1'b0);
    done = 1'b0; req = 3'b000;
    step();

`ifdef ARB_TIMEOUT_EN
    tmo_tenure("tmo", 1'b0);
    tmo_tenure("tc_rel", 1'b1);
`else
    req = 3'b001;
    step();
    chk_out("hold.grant", 3'b001, 2'd0, 1'b1, 1'b0);
    tmo_seen = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (timeout !== 1'b0) tmo_seen++;
    end
    chk_out("hold.c100", 3'b001, 2'd0, 1'b1, 1'b0);
    chk("hold.no_timeout", 32'(tmo_seen), 32'd0);
    done = 1'b1;
    step();
    chk_out("hold.end", 3'b000, 2'd0, 1'b0, 1'b0);
    done = 1'b0; req = 3'b000;
    step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
